// File: rtl/piso_register_reader.sv
// piso_register_reader: captures a WIDTH-bit word and serializes it over a valid/ready link.
// Define PISO_PARITY_EN to append an even-parity beat after the data bits.
module piso_register_reader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  input  logic             sout_ready,
  output logic             busy
);
`ifdef PISO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(N - 2);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t         state_q;
  logic [N-1:0]   shift_q;
  logic [CW-1:0]  cnt_q;
  logic           sout_q, sout_valid_q, sout_last_q;
  logic [WIDTH-1:0] ord;
  logic [N-1:0]   frame;
  // Frame is arranged in send order, first beat at the top bit.
  assign ord = MSB_FIRST ? din : {<<{din}};
`ifdef PISO_PARITY_EN
  assign frame = {ord, ^din};
`else
  assign frame = ord;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (load_valid) begin
        state_q      <= SHIFT;
        shift_q      <= frame << 1;
        cnt_q        <= '0;
        sout_q       <= frame[N-1];
        sout_valid_q <= 1'b1;
        sout_last_q  <= 1'b0;
      end
    end else if (sout_ready) begin
      if (cnt_q == LAST) begin
        state_q      <= IDLE;
        sout_q       <= 1'b0;
        sout_valid_q <= 1'b0;
        sout_last_q  <= 1'b0;
      end else begin
        shift_q     <= shift_q << 1;
        sout_q      <= shift_q[N-1];
        cnt_q       <= cnt_q + 1'b1;
        sout_last_q <= (cnt_q == PRE_LAST);
      end
    end
  end
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_last  = sout_last_q;
endmodule

// File: tb/tb_piso_register_reader.sv
// tb_piso_register_reader: directed and random frames on MSB-first and LSB-first readers against a bit-queue model.
module tb_piso_register_reader;
  logic       clk = 1'b0;
  logic       rst_n, load_valid, sout_ready;
  logic [7:0] din;
  logic       lr_m, so_m, sv_m, sl_m, bz_m;
  logic       lr_l, so_l, sv_l, sl_l, bz_l;
  int         n_assert = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  piso_register_reader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid), .load_ready(lr_m),
    .sout(so_m), .sout_valid(sv_m), .sout_last(sl_m), .sout_ready(sout_ready), .busy(bz_m)
  );
  piso_register_reader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid), .load_ready(lr_l),
    .sout(so_l), .sout_valid(sv_l), .sout_last(sl_l), .sout_ready(sout_ready), .busy(bz_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " sout_valid"}, sv_m, 1'b0);
    chk({tag, " sout_last"}, sl_m, 1'b0);
    chk({tag, " busy"}, bz_m, 1'b0);
    chk({tag, " load_ready"}, lr_m, 1'b1);
    chk({tag, " sout"}, so_m, 1'b0);
    chk({tag, " lsb busy"}, bz_l, 1'b0);
    chk({tag, " lsb load_ready"}, lr_l, 1'b1);
    chk({tag, " lsb sout_valid"}, sv_l, 1'b0);
  endtask

  // Loads w, walks every beat (optional stall/abort), checks the idle state afterwards.
  task automatic run_frame(input logic [7:0] w, input int stall_at, input int stall_len,
                           input bit junk, input int abort_at);
    logic exp_m[$];
    logic exp_l[$];
    int   n;
    for (int i = 0; i < 8; i++) begin
      exp_m.push_back(w[7-i]);
      exp_l.push_back(w[i]);
    end
`ifdef PISO_PARITY_EN
    exp_m.push_back(^w);
    exp_l.push_back(^w);
`endif
    n = exp_m.size();
    din = w;
    load_valid = 1'b1;
    step;
    if (junk) din = 8'hFF;
    else begin
      load_valid = 1'b0;
      din = 8'($urandom);
    end
    for (int k = 0; k < n; k++) begin
      chk($sformatf("w%h b%0d sout msb", w, k), so_m, exp_m[k]);
      chk($sformatf("w%h b%0d sout lsb", w, k), so_l, exp_l[k]);
      chk($sformatf("w%h b%0d sout_valid", w, k), sv_m, 1'b1);
      chk($sformatf("w%h b%0d sout_valid lsb", w, k), sv_l, 1'b1);
      chk($sformatf("w%h b%0d sout_last", w, k), sl_m, k == n - 1);
      chk($sformatf("w%h b%0d sout_last lsb", w, k), sl_l, k == n - 1);
      chk($sformatf("w%h b%0d busy", w, k), bz_m, 1'b1);
      chk($sformatf("w%h b%0d load_ready", w, k), lr_m, 1'b0);
      if (k == abort_at) begin
        rst_n = 1'b0;
        load_valid = 1'b0;
        #1;
        chk_idle("async reset");
        #2;
        rst_n = 1'b1;
        return;
      end
      if (k == stall_at) begin
        sout_ready = 1'b0;
        repeat (stall_len) begin
          step;
          chk($sformatf("w%h stall b%0d sout", w, k), so_m, exp_m[k]);
          chk($sformatf("w%h stall b%0d sout lsb", w, k), so_l, exp_l[k]);
          chk($sformatf("w%h stall b%0d sout_valid", w, k), sv_m, 1'b1);
          chk($sformatf("w%h stall b%0d sout_last", w, k), sl_m, k == n - 1);
        end
        sout_ready = 1'b1;
      end
      step;
    end
    chk_idle($sformatf("w%h end", w));
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    sout_ready = 1'b1;
    din = 8'h00;
    #12;
    chk_idle("reset");
    rst_n = 1'b1;
    step;
    chk_idle("post reset");
    run_frame(8'hA5, -1, 0, 1'b0, -1);
    run_frame(8'h01, -1, 0, 1'b0, -1);
    step;
    run_frame(8'hA5, 3, 3, 1'b0, -1);
    run_frame(8'hA5, -1, 0, 1'b1, -1);
    run_frame(8'hFF, -1, 0, 1'b0, -1);
    run_frame(8'h3C, -1, 0, 1'b0, 4);
    step;
    chk_idle("after abort");
    run_frame(8'hC3, -1, 0, 1'b0, -1);
    run_frame(8'h07, -1, 0, 1'b0, -1);
    run_frame(8'hFF, 8, 2, 1'b0, -1);
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 1) == 1) step;
      run_frame(8'($urandom), int'($urandom_range(0, 8)), int'($urandom_range(0, 4)), 1'b0, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
